// File: rtl/codec_err_monitor_if.sv
// Handshake bus of the codec error monitor: codeword input stream and
// corrected-data output stream, each with its own valid/ready pair.
interface codec_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] code_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic [1:0]  status;

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, status
  );

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, status
  );
endinterface

// File: rtl/codec_err_monitor.sv
// Two-stage 2-D parity decoder for 16-bit words: syndrome stage, then
// correct/classify stage, with saturating event counters and a sticky alarm.
module codec_err_monitor #(
  parameter int CNT_W    = 16,
  parameter int ALARM_TH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  codec_err_monitor_if.slave   bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     cnt_clean,
  output logic [CNT_W-1:0]     cnt_corr,
  output logic [CNT_W-1:0]     cnt_uncorr,
  output logic                 alarm
);

  function automatic logic [3:0] row_par(input logic [15:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[4*i +: 4];
    return p;
  endfunction

  function automatic logic [3:0] col_par(input logic [15:0] d);
    logic [3:0] p;
    for (int j = 0; j < 4; j++) p[j] = d[j] ^ d[j+4] ^ d[j+8] ^ d[j+12];
    return p;
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Returns {status, data}; a single row/column crossing pinpoints one data bit.
  function automatic logic [17:0] classify(input logic [15:0] d,
                                           input logic [3:0]  r,
                                           input logic [3:0]  c);
    logic [15:0] fixed;
    logic [1:0]  st;
    logic [2:0]  pr;
    logic [2:0]  pc;
    fixed = d;
    st    = 2'b11;
    pr    = popcnt4(r);
    pc    = popcnt4(c);
    if (r == 4'd0 && c == 4'd0) begin
      st = 2'b00;
    end else if (pr == 3'd1 && pc == 3'd1) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (r[i] && c[j]) fixed[4*i+j] = ~d[4*i+j];
      st = 2'b01;
    end else if (pr + pc == 3'd1) begin
      st = 2'b10;
    end
    return {st, fixed};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [23:0]       s1_code_q, s1_code_d;
  logic [3:0]        s1_r_q, s1_r_d;
  logic [3:0]        s1_c_q, s1_c_d;
  logic              s2_valid_q, s2_valid_d;
  logic [15:0]       s2_data_q, s2_data_d;
  logic [1:0]        s2_status_q, s2_status_d;
  logic [CNT_W-1:0]  cnt_clean_q, cnt_clean_d;
  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;
  logic              alarm_q, alarm_d;

  logic s2_ready;
  logic in_ready;
  logic in_fire;
  logic out_fire;

  assign s2_ready = !s2_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = s2_valid_q && bus.out_ready;

  // Stage 1: capture codeword and both syndromes
  always_comb begin
    s1_code_d  = s1_code_q;
    s1_r_d     = s1_r_q;
    s1_c_d     = s1_c_q;
    s1_valid_d = in_fire || (s1_valid_q && !s2_ready);
    if (in_fire) begin
      s1_code_d = bus.code_in;
      s1_r_d    = row_par(bus.code_in[15:0]) ^ bus.code_in[19:16];
      s1_c_d    = col_par(bus.code_in[15:0]) ^ bus.code_in[23:20];
    end
  end

  // Stage 2: correct and classify; holds while downstream stalls
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_status_d = s2_status_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) {s2_status_d, s2_data_d} = classify(s1_code_q[15:0], s1_r_q, s1_c_q);
    end
  end

  // Event counters: clear wins over a same-cycle output handshake
  always_comb begin
    cnt_clean_d  = cnt_clean_q;
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    alarm_d      = alarm_q || (32'(cnt_uncorr_q) >= ALARM_TH);
    if (clr_cnt) begin
      cnt_clean_d  = '0;
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
      alarm_d      = 1'b0;
    end else if (out_fire) begin
      case (s2_status_q)
        2'b00:   cnt_clean_d  = sat_inc(cnt_clean_q);
        2'b11:   cnt_uncorr_d = sat_inc(cnt_uncorr_q);
        default: cnt_corr_d   = sat_inc(cnt_corr_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_status_q  <= '0;
      cnt_clean_q  <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
      alarm_q      <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_status_q  <= s2_status_d;
      cnt_clean_q  <= cnt_clean_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
      alarm_q      <= alarm_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_code_q <= s1_code_d;
    s1_r_q    <= s1_r_d;
    s1_c_q    <= s1_c_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.data_out  = s2_data_q;
  assign bus.status    = s2_status_q;
  assign cnt_clean     = cnt_clean_q;
  assign cnt_corr      = cnt_corr_q;
  assign cnt_uncorr    = cnt_uncorr_q;
  assign alarm         = alarm_q;

endmodule

// File: tb/tb_codec_err_monitor.sv
// Scoreboard bench for codec_err_monitor: directed codewords, expected
// {data,status} queued at input handshake, compared by an output monitor.
module tb_codec_err_monitor;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_cnt;
  always #5 clk = ~clk;

  codec_err_monitor_if bif ();
  codec_err_monitor_if sif ();

  assign sif.in_valid  = bif.in_valid;
  assign sif.code_in   = bif.code_in;
  assign sif.out_ready = bif.out_ready;

  logic [15:0] cnt_clean, cnt_corr, cnt_uncorr;
  logic        alarm;
  logic [1:0]  s_cnt_clean, s_cnt_corr, s_cnt_uncorr;
  logic        s_alarm;

  codec_err_monitor #(.CNT_W(16), .ALARM_TH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave), .clr_cnt(clr_cnt),
    .cnt_clean(cnt_clean), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr), .alarm(alarm)
  );

  codec_err_monitor #(.CNT_W(2), .ALARM_TH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sif.slave), .clr_cnt(clr_cnt),
    .cnt_clean(s_cnt_clean), .cnt_corr(s_cnt_corr), .cnt_uncorr(s_cnt_uncorr), .alarm(s_alarm)
  );

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] held;
  logic        held_vld = 1'b0;

  localparam logic [23:0] CW_CLEAN = 24'h00A5C3;
  localparam logic [23:0] CW_BIT6  = 24'h00A583;
  localparam logic [23:0] CW_P21   = 24'h20A5C3;
  localparam logic [23:0] CW_P16   = 24'h01A5C3;
  localparam logic [23:0] CW_DBL   = 24'h00A5E2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops on handshake, checks stability while stalled
  always @(negedge clk) begin
    if (rst_n && bif.out_valid) begin
      if (bif.out_ready) begin
        held_vld = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %h status %b, nothing expected", bif.data_out, bif.status);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("data_out", 32'(bif.data_out), 32'(e[17:2]));
          chk("status", 32'(bif.status), 32'(e[1:0]));
        end
      end else begin
        if (held_vld) chk("stall_hold", 32'({bif.data_out, bif.status}), 32'(held));
        held     = {bif.data_out, bif.status};
        held_vld = 1'b1;
      end
    end else begin
      held_vld = 1'b0;
    end
  end

  task automatic send(input logic [23:0] code, input logic [15:0] ed, input logic [1:0] es);
    int guard;
    guard = 0;
    bif.in_valid = 1'b1;
    bif.code_in  = code;
    @(negedge clk);
    while (!bif.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bif.in_ready) chk("in_ready_timeout", 32'(bif.in_ready), 32'd1);
    else exp_q.push_back({ed, es});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr_cnt = 1'b0;
    bif.in_valid = 1'b0;
    bif.code_in = '0;
    bif.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_data_out", 32'(bif.data_out), 32'd0);
    chk("rst_status", 32'(bif.status), 32'd0);
    chk("rst_counters", 32'({cnt_clean, cnt_corr, cnt_uncorr}), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 32'(bif.in_ready), 32'd1);

    // Saturation: five clean words into both instances
    repeat (5) send(CW_CLEAN, 16'hA5C3, 2'b00);
    idle();
    drain();
    chk("cnt_clean_16b", 32'(cnt_clean), 32'd5);
    chk("cnt_clean_sat", 32'(s_cnt_clean), 32'd3);
    pulse_clr();
    chk("clr_cnt_clean", 32'(cnt_clean), 32'd0);
    chk("clr_cnt_clean_sat", 32'(s_cnt_clean), 32'd0);

    // Clean word and two-cycle latency
    send(CW_CLEAN, 16'hA5C3, 2'b00);
    idle();
    chk("latency_cycle1", 32'(bif.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_cycle2", 32'(bif.out_valid), 32'd1);
    drain();
    chk("cnt_clean_one", 32'(cnt_clean), 32'd1);

    send(CW_BIT6, 16'hA5C3, 2'b01);
    idle();
    drain();
    chk("cnt_corr_one", 32'(cnt_corr), 32'd1);

    send(CW_P21, 16'hA5C3, 2'b10);
    send(CW_P16, 16'hA5C3, 2'b10);
    idle();
    drain();
    chk("cnt_corr_three", 32'(cnt_corr), 32'd3);
    chk("cnt_uncorr_zero", 32'(cnt_uncorr), 32'd0);

    repeat (4) send(CW_DBL, 16'hA5E2, 2'b11);
    idle();
    drain();
    chk("cnt_uncorr_four", 32'(cnt_uncorr), 32'd4);
    chk("alarm_set", 32'(alarm), 32'd1);
    @(posedge clk);
    #1;
    chk("alarm_sticky", 32'(alarm), 32'd1);
    pulse_clr();
    chk("alarm_cleared", 32'(alarm), 32'd0);
    chk("cnt_uncorr_cleared", 32'(cnt_uncorr), 32'd0);
    chk("cnt_corr_cleared", 32'(cnt_corr), 32'd0);

    // Clear coinciding with an output handshake: word emerges, not counted
    send(CW_CLEAN, 16'hA5C3, 2'b00);
    idle();
    @(posedge clk);
    #1;
    chk("clr_hs_out_valid", 32'(bif.out_valid), 32'd1);
    pulse_clr();
    chk("clr_hs_not_counted", 32'(cnt_clean), 32'd0);
    chk("clr_hs_consumed", 32'(bif.out_valid), 32'd0);

    // Backpressure: three stalled cycles while streaming five words
    bif.out_ready = 1'b0;
    fork
      begin
        send(24'h4D1234, 16'h1234, 2'b00);
        send(24'h00FFFF, 16'hFFFF, 2'b00);
        send(CW_BIT6,    16'hA5C3, 2'b01);
        send(24'h003C3C, 16'h3C3C, 2'b00);
        send(24'h006969, 16'h6969, 2'b00);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_low", 32'(bif.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bif.out_valid), 32'd1);
        bif.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_cnt_clean", 32'(cnt_clean), 32'd4);
    chk("bp_cnt_corr", 32'(cnt_corr), 32'd1);

    // Reset mid-stream
    send(CW_CLEAN, 16'hA5C3, 2'b00);
    send(24'h00FFFF, 16'hFFFF, 2'b00);
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    chk("async_rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("async_rst_data_out", 32'(bif.data_out), 32'd0);
    chk("async_rst_status", 32'(bif.status), 32'd0);
    chk("async_rst_cnt_clean", 32'(cnt_clean), 32'd0);
    chk("async_rst_cnt_corr", 32'(cnt_corr), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("no_stale_output", 32'(bif.out_valid), 32'd0);
    end
    send(CW_CLEAN, 16'hA5C3, 2'b00);
    idle();
    drain();
    chk("post_rst_cnt_clean", 32'(cnt_clean), 32'd1);
    chk("post_rst_cnt_clean_sat", 32'(s_cnt_clean), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_err_monitor.md
CODEC_ERR_MONITOR -- requirements
Module: codec_err_monitor

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of each event counter.
REQ-002 The module SHALL have parameter ALARM_TH, default 4, giving the uncorrectable-event count that raises alarm.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a received codeword is present on code_in.
REQ-006 in_ready  output  1  the module accepts code_in this cycle.
REQ-007 code_in  input  24  received codeword: [15:0] data d, [19:16] row parity, [23:20] column parity.
REQ-008 out_valid  output  1  data_out and status are valid.
REQ-009 out_ready  input  1  the downstream stage accepts the output.
REQ-010 data_out  output  16  corrected data word.
REQ-011 status  output  2  00 clean, 01 data bit corrected, 10 parity bit in error, 11 uncorrectable.
REQ-012 clr_cnt  input  1  synchronous clear of the counters and alarm.
REQ-013 cnt_clean, cnt_corr, cnt_uncorr  output  CNT_W each  saturating event counters.
REQ-014 alarm  output  1  sticky: cnt_uncorr >= ALARM_TH.

Function
REQ-015 Row parity p[16+i] SHALL be the XOR of d[4i+3:4i], for i = 0..3; column parity p[20+j] SHALL be the XOR of d[j], d[j+4], d[j+8] and d[j+12], for j = 0..3.
REQ-016 Stage 1 SHALL register code_in together with syndromes r[3:0] (recomputed row parity XOR received [19:16]) and c[3:0] (recomputed column parity XOR received [23:20]) on each handshake in_valid && in_ready.
REQ-017 Stage 2 SHALL classify each word as follows:
- r=0 and c=0: status 00.
- exactly one bit set in r (bit i) and exactly one set in c (bit j): flip d[4i+j] and report status 01.
- popcount(r)+popcount(c) == 1: data passes unchanged, status 10.
- any other case: data passes unchanged, status 11.
REQ-018 Latency from input handshake to out_valid SHALL be 2 cycles with no stalls; the pipeline SHALL sustain one word per cycle while out_ready=1.
REQ-019 The pipeline SHALL use valid/ready per stage: a stage SHALL load when it is empty or when its contents are consumed in the same cycle.
- in_ready = !s1_valid || (stage 2 can accept).
- in_ready SHALL be combinational, with no added bubble.
REQ-020 While out_valid=1 and out_ready=0, data_out, status and out_valid SHALL hold stable.
REQ-021 Each counter SHALL increment by one on the output handshake (out_valid && out_ready) whose status matches it: 00 -> cnt_clean; 01 or 10 -> cnt_corr; 11 -> cnt_uncorr.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 alarm SHALL set in the cycle after cnt_uncorr reaches ALARM_TH and SHALL remain set until clr_cnt or reset.
REQ-024 clr_cnt SHALL zero all counters and alarm next edge; a handshake in the same cycle SHALL be discarded from counting. Pipeline contents SHALL be unaffected.

Reset
REQ-025 On rst_n low, all of the following SHALL be zero immediately and independent of clk:
- s1_valid, s2_valid, out_valid
- data_out, status
- all counters and alarm
REQ-026 in_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-027 Words in flight when reset asserts SHALL be discarded and SHALL NOT be counted.

Verification
REQ-028 Clean word: code_in built from d=16'hA5C3 with correct parity, out_ready=1 -> two cycles later data_out=16'hA5C3, status=00, cnt_clean=1.
REQ-029 Single data error: the same codeword with bit 6 flipped (r=0010, c=0100) -> data_out=16'hA5C3, status=01, cnt_corr=1.
REQ-030 Parity-bit error: the same codeword with bit 21 flipped -> data_out=16'hA5C3, status=10.
REQ-031 Double data error: bits 0 and 5 flipped -> status=11, data unchanged. Repeating this 4 times sets alarm; clr_cnt clears it next cycle.
REQ-032 Backpressure: stream 5 words with out_ready=0 for 3 cycles, then 1 -> in_ready drops once both stages are full; all 5 outputs emerge in order, unchanged, with no duplicates.
REQ-033 Saturation and reset: CNT_W=2, 5 clean words -> cnt_clean=3. Asserting rst_n low mid-stream -> all outputs zero asynchronously and no stale output after release.
